// File: rtl/cmp_pkg.sv
// Shared types and constants for the comparator self-test driver.
// The LFSR tap table is used only when CMP_DRV_LFSR_EN is defined.
package cmp_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLR,
        ST_DRIVE,
        ST_WAIT,
        ST_CHECK,
        ST_DONE
    } state_e;

    // One-hot relation encoding {lt, eq, gt}
    localparam logic [2:0] REL_LT = 3'b100;
    localparam logic [2:0] REL_EQ = 3'b010;
    localparam logic [2:0] REL_GT = 3'b001;

    localparam int unsigned ERR_W   = 8;
    localparam logic [7:0]  ERR_MAX = 8'hFF;

    // Right-shifting Galois feedback masks giving maximal-length sequences
    function automatic logic [31:0] lfsr_taps(input int unsigned n);
        case (n)
            2:       return 32'h0000_0003;
            4:       return 32'h0000_000C;
            6:       return 32'h0000_0030;
            8:       return 32'h0000_00B8;
            10:      return 32'h0000_0240;
            12:      return 32'h0000_0E08;
            14:      return 32'h0000_3802;
            16:      return 32'h0000_B400;
            20:      return 32'h0009_0000;
            24:      return 32'h00E1_0000;
            default: return 32'h8020_0003;
        endcase
    endfunction

endpackage

// File: rtl/cmp_operand_gen.sv
// Operand stream {a,b} for the comparator driver.
// CMP_DRV_LFSR_EN selects a Galois LFSR seeded with SEED; otherwise a
// wrapping up-counter that starts from zero.
module cmp_operand_gen
    import cmp_pkg::*;
#(
    parameter int unsigned W2 = 8
`ifdef CMP_DRV_LFSR_EN
    , parameter logic [W2-1:0] SEED = W2'(8'hA5)
`endif
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          i_load,
    input  logic          i_adv,
    output logic [W2-1:0] o_ops
);

    logic [W2-1:0] r_ops;
    logic [W2-1:0] w_ops_next;

`ifdef CMP_DRV_LFSR_EN
    localparam logic [W2-1:0] TAPS = W2'(lfsr_taps(W2));

    // Galois step: shift right, fold taps in when the output bit is set
    always_comb begin
        w_ops_next = r_ops >> 1;
        if (r_ops[0]) begin
            w_ops_next = (r_ops >> 1) ^ TAPS;
        end
    end

    // Sequence register: seeded on load, stepped on advance
    always_ff @(posedge clk) begin
        if (reset) begin
            r_ops <= '0;
        end else if (i_load) begin
            r_ops <= SEED;
        end else if (i_adv) begin
            r_ops <= w_ops_next;
        end
    end
`else
    // Wrapping increment
    always_comb begin
        w_ops_next = r_ops + W2'(1);
    end

    // Sequence register: cleared on load, stepped on advance
    always_ff @(posedge clk) begin
        if (reset) begin
            r_ops <= '0;
        end else if (i_load) begin
            r_ops <= '0;
        end else if (i_adv) begin
            r_ops <= w_ops_next;
        end
    end
`endif

    assign o_ops = r_ops;

endmodule

// File: rtl/comparator_driver.sv
// Self-test initiator for the multi-bit comparator: runs N_VECTORS operand
// pairs through the comparator reset/enable sequence, checks the flags
// against an unsigned reference and reports vector/error counts.
// Optional macro CMP_DRV_LFSR_EN switches the operand source to an LFSR.
module comparator_driver
    import cmp_pkg::*;
#(
    parameter int unsigned WIDTH     = 4,
    parameter int unsigned N_VECTORS = 16,
    parameter int unsigned LAT       = 1,
    parameter logic [31:0] SEED      = 32'h0000_00A5
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             start,
    output logic                             busy,
    output logic                             done,
    output logic                             dut_reset,
    output logic                             dut_enable,
    output logic [WIDTH-1:0]                 a_out,
    output logic [WIDTH-1:0]                 b_out,
    input  logic                             less_than_in,
    input  logic                             equal_to_in,
    input  logic                             greater_than_in,
    output logic [$clog2(N_VECTORS+1)-1:0]   vec_count,
    output logic [ERR_W-1:0]                 err_count,
    output logic                             pass
);

    localparam int unsigned W2    = 2 * WIDTH;
    localparam int unsigned VC_W  = $clog2(N_VECTORS + 1);
    localparam int unsigned LAT_W = $clog2(LAT + 1);

    // Reject configurations the sequencing cannot support
    if (N_VECTORS < 1 || LAT < 1 || SEED == 32'd0) begin : g_bad_cfg
        $error("comparator_driver: N_VECTORS, LAT and SEED must be nonzero");
    end

    state_e            r_state;
    state_e            w_next;
    logic              r_busy;
    logic              r_done;
    logic              r_dut_reset;
    logic              r_dut_enable;
    logic [VC_W-1:0]   r_vec;
    logic [ERR_W-1:0]  r_err;
    logic              r_pass;
    logic [LAT_W-1:0]  r_wait;

    logic [W2-1:0]     w_ops;
    logic [WIDTH-1:0]  w_a;
    logic [WIDTH-1:0]  w_b;
    logic [2:0]        w_flags;
    logic [2:0]        w_exp;
    logic              w_mismatch;
    logic              w_load;
    logic              w_adv;
    logic [VC_W-1:0]   w_vec_next;
    logic [ERR_W-1:0]  w_err_next;

    cmp_operand_gen #(
        .W2   (W2)
`ifdef CMP_DRV_LFSR_EN
        , .SEED (W2'(SEED))
`endif
    ) u_gen (
        .clk    (clk),
        .reset  (reset),
        .i_load (w_load),
        .i_adv  (w_adv),
        .o_ops  (w_ops)
    );

    assign w_a     = w_ops[W2-1:WIDTH];
    assign w_b     = w_ops[WIDTH-1:0];
    assign w_flags = {less_than_in, equal_to_in, greater_than_in};

    // Unsigned reference relation; any flag pattern other than it is an error
    always_comb begin
        w_exp = REL_GT;
        if (w_a < w_b) begin
            w_exp = REL_LT;
        end else if (w_a == w_b) begin
            w_exp = REL_EQ;
        end
        w_mismatch = (w_flags != w_exp);
    end

    // Next state, generator control and next counter values
    always_comb begin
        w_next     = r_state;
        w_load     = 1'b0;
        w_adv      = 1'b0;
        w_vec_next = r_vec;
        w_err_next = r_err;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_next     = ST_CLR;
                    w_load     = 1'b1;
                    w_vec_next = '0;
                    w_err_next = '0;
                end
            end
            ST_CLR:   w_next = ST_DRIVE;
            ST_DRIVE: w_next = ST_WAIT;
            ST_WAIT: begin
                if (r_wait == '0) begin
                    w_next = ST_CHECK;
                end
            end
            ST_CHECK: begin
                w_adv      = 1'b1;
                w_vec_next = r_vec + VC_W'(1);
                if (w_mismatch && (r_err != ERR_MAX)) begin
                    w_err_next = r_err + ERR_W'(1);
                end
                w_next = (r_vec == VC_W'(N_VECTORS - 1)) ? ST_DONE : ST_CLR;
            end
            ST_DONE:  w_next = ST_IDLE;
            default:  w_next = ST_IDLE;
        endcase
    end

    // State and registered outputs, all derived from the upcoming state
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_dut_reset  <= 1'b1;
            r_dut_enable <= 1'b0;
            r_vec        <= '0;
            r_err        <= '0;
            r_pass       <= 1'b0;
            r_wait       <= '0;
        end else begin
            r_state      <= w_next;
            r_busy       <= (w_next inside {ST_CLR, ST_DRIVE, ST_WAIT, ST_CHECK});
            r_done       <= (w_next == ST_DONE);
            r_dut_reset  <= (w_next == ST_CLR);
            r_dut_enable <= (w_next == ST_DRIVE);
            r_vec        <= w_vec_next;
            r_err        <= w_err_next;
            if (w_load) begin
                r_pass <= 1'b0;
            end else if (w_next == ST_DONE) begin
                r_pass <= (w_err_next == '0);
            end
            if (r_state == ST_DRIVE) begin
                r_wait <= LAT_W'(LAT - 1);
            end else if ((r_state == ST_WAIT) && (r_wait != '0)) begin
                r_wait <= r_wait - LAT_W'(1);
            end
        end
    end

    assign busy       = r_busy;
    assign done       = r_done;
    assign dut_reset  = r_dut_reset;
    assign dut_enable = r_dut_enable;
    assign a_out      = w_a;
    assign b_out      = w_b;
    assign vec_count  = r_vec;
    assign err_count  = r_err;
    assign pass       = r_pass;

endmodule
